// File: rtl/dac_driver_pkg.sv
// Shared types and constants for the dac_driver output stage: gain FSM states,
// dither LFSR constants and the offset-binary midscale helper.
package dac_driver_pkg;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } gain_state_e;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int midscale(input int out_w);
    return 1 << (out_w - 1);
  endfunction

endpackage

// File: rtl/dac_chan_scale.sv
// One channel of the dac_driver datapath: gain multiply, dither add and floor
// shift (stage 2), then alignment and offset-binary conversion (stage 3).
module dac_chan_scale
  import dac_driver_pkg::*;
#(
  parameter int IN_W      = 5,
  parameter int OUT_W     = 6,
  parameter int GAIN_W    = 4,
  parameter int MSB_ALIGN = 0
) (
  input  logic                     pll_clock,
  input  logic                     reset,
  input  logic                     load_mult,
  input  logic                     load_out,
  input  logic signed [IN_W-1:0]   sample,
  input  logic        [GAIN_W:0]   gain,
  input  logic        [GAIN_W-1:0] dither,
  output logic        [OUT_W-1:0]  dac_code
);

  localparam int PW = IN_W + GAIN_W + 1;

  logic signed [PW-1:0]    s_x, g_x, d_x, prod, shifted;
  logic signed [IN_W-1:0]  q_reg;
  logic signed [OUT_W-1:0] a_ext, aligned;
  logic        [OUT_W-1:0] code_next;
  logic                    unused_hi;

  always_comb begin
    s_x     = PW'(sample);
    g_x     = PW'(gain);
    d_x     = PW'(dither);
    prod    = s_x * g_x + d_x;
    // Dither is below one LSB of the result, so the floor never exceeds the sample.
    shifted = prod >>> GAIN_W;
  end

  assign unused_hi = ^shifted[PW-1:IN_W];

  always_comb begin
    a_ext     = OUT_W'(q_reg);
    aligned   = (MSB_ALIGN != 0) ? (a_ext <<< (OUT_W - IN_W)) : a_ext;
    code_next = aligned + OUT_W'(midscale(OUT_W));
  end

  always_ff @(posedge pll_clock) begin
    if (reset) begin
      q_reg    <= '0;
      dac_code <= OUT_W'(midscale(OUT_W));
    end else begin
      if (load_mult) q_reg    <= shifted[IN_W-1:0];
      if (load_out)  dac_code <= code_next;
    end
  end

endmodule

// File: rtl/dac_driver.sv
// Multi-channel signed-to-offset-binary DAC driver with soft-mute gain ramp.
// Define DAC_DRIVER_DITHER_EN to add LFSR truncation dither during ramps.
module dac_driver
  import dac_driver_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int IN_W      = 5,
  parameter int OUT_W     = 6,
  parameter int GAIN_W    = 4,
  parameter int RAMP_DIV  = 2,
  parameter int MSB_ALIGN = 0
) (
  input  logic                      pll_clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS*IN_W-1:0]  sample_in,
  input  logic                      sample_valid,
  output logic [CHANNELS*OUT_W-1:0] dac_code,
  output logic                      out_valid,
  output logic                      muted,
  output logic [GAIN_W:0]           gain
);

  localparam int             PRE_W     = (RAMP_DIV > 0) ? RAMP_DIV : 1;
  localparam logic [GAIN_W:0] GAIN_FULL = {1'b1, {GAIN_W{1'b0}}};

  if (OUT_W < IN_W) begin : g_bad_width
    $error("dac_driver: OUT_W must be >= IN_W");
  end
  if (GAIN_W > LFSR_W) begin : g_bad_gain
    $error("dac_driver: GAIN_W must not exceed the LFSR width");
  end

  gain_state_e          state, state_next;
  logic [GAIN_W:0]      gain_q, gain_next;
  logic [PRE_W-1:0]     presc, presc_next;
  logic                 ramping, step;

  // State register, with the gain envelope and prescaler it controls.
  always_ff @(posedge pll_clock) begin
    // NOTE: non-blocking here so every flop updates from pre-edge values.
    if (reset) begin
      state  <= MUTED;
      gain_q <= '0;
      presc  <= '0;
    end else begin
      state  <= state_next;
      gain_q <= gain_next;
      presc  <= presc_next;
    end
  end

  assign ramping = (state == RAMP_UP) || (state == RAMP_DOWN);
  assign step    = (RAMP_DIV == 0) || (presc == '1);

  // Next state: enable always wins over the gain reaching its bound.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    state_next = state;
    gain_next  = gain_q;
    case (state)
      MUTED: begin
        gain_next = '0;
        if (enable) state_next = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enable) begin
          state_next = RAMP_DOWN;
        end else begin
          if (step && gain_q != GAIN_FULL) gain_next = gain_q + 1'b1;
          if (gain_next == GAIN_FULL) state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        gain_next = GAIN_FULL;
        if (!enable) state_next = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (enable) begin
          state_next = RAMP_UP;
        end else begin
          if (step && gain_q != '0) gain_next = gain_q - 1'b1;
          if (gain_next == '0) state_next = MUTED;
        end
      end
      default: state_next = MUTED;
    endcase
    presc_next = (state_next != state || !ramping) ? '0 : presc + 1'b1;
  end

  always_comb begin
    muted = (state == MUTED);
    gain  = gain_q;
  end

  // Stage 1: samples and one gain snapshot shared by all channels.
  logic [CHANNELS*IN_W-1:0] s1_sample;
  logic [GAIN_W:0]          s1_gain;
  logic                     s1_valid, s2_valid, s3_valid;

  always_ff @(posedge pll_clock) begin
    if (reset) begin
      s1_sample <= '0;
      s1_gain   <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
    end else begin
      s1_valid <= sample_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      if (sample_valid) begin
        s1_sample <= sample_in;
        s1_gain   <= gain_q;
      end
    end
  end

  assign out_valid = s3_valid;

`ifdef DAC_DRIVER_DITHER_EN
  logic [LFSR_W-1:0] lfsr;
  logic              dither_on;

  always_ff @(posedge pll_clock) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
  end

  // Full and zero gain stay exact; dither only shapes the ramp.
  assign dither_on = (s1_gain != '0) && (s1_gain != GAIN_FULL);
`endif

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic [GAIN_W-1:0] dither;

`ifdef DAC_DRIVER_DITHER_EN
    always_comb begin
      dither = '0;
      for (int b = 0; b < GAIN_W; b++) begin
        dither[b] = dither_on & lfsr[4'((k * GAIN_W + b) % LFSR_W)];
      end
    end
`else
    assign dither = '0;
`endif

    dac_chan_scale #(
      .IN_W     (IN_W),
      .OUT_W    (OUT_W),
      .GAIN_W   (GAIN_W),
      .MSB_ALIGN(MSB_ALIGN)
    ) u_scale (
      .pll_clock(pll_clock),
      .reset    (reset),
      .load_mult(s1_valid),
      .load_out (s2_valid),
      .sample   (s1_sample[k*IN_W +: IN_W]),
      .gain     (s1_gain),
      .dither   (dither),
      .dac_code (dac_code[k*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_dac_driver.sv
// Self-checking bench for dac_driver: directed ramp/mute/latency scenarios plus
// randomized traffic, compared against a behavioural gain and pipeline model.
module tb_dac_driver;

  localparam int CH     = 2;
  localparam int IN_W   = 5;
  localparam int OUT_W  = 6;
  localparam int GAIN_W = 4;
  localparam int FULL   = 1 << GAIN_W;
  localparam int MID    = 1 << (OUT_W - 1);
  localparam int DIV    = 4;

  localparam int M_MUTED  = 0;
  localparam int M_UP     = 1;
  localparam int M_ACTIVE = 2;
  localparam int M_DOWN   = 3;

  logic                  pll_clock = 1'b0;
  logic                  reset, enable, sample_valid;
  logic [CH*IN_W-1:0]    sample_in;
  logic [CH*OUT_W-1:0]   code_a, code_b;
  logic                  ov_a, ov_b, muted_a, muted_b;
  logic [GAIN_W:0]       gain_a, gain_b;

  always #5 pll_clock = ~pll_clock;

  dac_driver #(.CHANNELS(CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W),
               .RAMP_DIV(2), .MSB_ALIGN(0)) dut (
    .pll_clock(pll_clock), .reset(reset), .enable(enable),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .dac_code(code_a), .out_valid(ov_a), .muted(muted_a), .gain(gain_a)
  );

  dac_driver #(.CHANNELS(CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W),
               .RAMP_DIV(2), .MSB_ALIGN(1)) dut_msb (
    .pll_clock(pll_clock), .reset(reset), .enable(enable),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .dac_code(code_b), .out_valid(ov_b), .muted(muted_b), .gain(gain_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Behavioural model: envelope by the ramp rules, outputs as a due-time queue.
  typedef struct {
    int due;
    int a0, a1, b0, b1;
  } exp_t;

  exp_t pend[$];
  int   m_state = M_MUTED, m_gain = 0, m_presc = 0;
  int   s_val[CH];
  int   e_a0 = MID, e_a1 = MID, e_b0 = MID, e_b1 = MID, e_valid = 0;

  function automatic int scale_code(input int s, input int g, input bit msb);
    int p, q;
    p = s * g;
    q = (p >= 0) ? p / FULL : -((-p + FULL - 1) / FULL);
    return (msb ? q * (1 << (OUT_W - IN_W)) : q) + MID;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_state = M_MUTED; m_gain = 0; m_presc = 0;
      pend.delete();
      e_a0 = MID; e_a1 = MID; e_b0 = MID; e_b1 = MID; e_valid = 0;
      cyc++;
      return;
    end
    if (sample_valid)
      pend.push_back('{cyc + 2,
                       scale_code(s_val[0], m_gain, 1'b0), scale_code(s_val[1], m_gain, 1'b0),
                       scale_code(s_val[0], m_gain, 1'b1), scale_code(s_val[1], m_gain, 1'b1)});
    case (m_state)
      M_MUTED:  if (enable)  begin m_state = M_UP;   m_presc = 0; end
      M_ACTIVE: if (!enable) begin m_state = M_DOWN; m_presc = 0; end
      M_UP: begin
        if (!enable) begin
          m_state = M_DOWN; m_presc = 0;
        end else begin
          m_presc = (m_presc + 1) % DIV;
          if (m_presc == 0 && m_gain < FULL) m_gain++;
          if (m_gain == FULL) begin m_state = M_ACTIVE; m_presc = 0; end
        end
      end
      default: begin
        if (enable) begin
          m_state = M_UP; m_presc = 0;
        end else begin
          m_presc = (m_presc + 1) % DIV;
          if (m_presc == 0 && m_gain > 0) m_gain--;
          if (m_gain == 0) begin m_state = M_MUTED; m_presc = 0; end
        end
      end
    endcase
    e_valid = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e_a0 = pend[0].a0; e_a1 = pend[0].a1; e_b0 = pend[0].b0; e_b1 = pend[0].b1;
      e_valid = 1;
      void'(pend.pop_front());
    end
    cyc++;
  endtask

  task automatic compare_all();
    check("gain",        gain_a, m_gain);
    check("gain_msb",    gain_b, m_gain);
    check("muted",       muted_a, m_state == M_MUTED);
    check("muted_msb",   muted_b, m_state == M_MUTED);
    check("out_valid",   ov_a, e_valid);
    check("out_valid_m", ov_b, e_valid);
    check("code0",       code_a[0 +: OUT_W],     e_a0);
    check("code1",       code_a[OUT_W +: OUT_W], e_a1);
    check("code0_msb",   code_b[0 +: OUT_W],     e_b0);
    check("code1_msb",   code_b[OUT_W +: OUT_W], e_b1);
  endtask

  task automatic cycle(input bit rst, input bit en, input bit sv, input int s0, input int s1);
    reset        = rst;
    enable       = en;
    sample_valid = sv;
    s_val[0]     = s0;
    s_val[1]     = s1;
    sample_in    = {IN_W'(s1), IN_W'(s0)};
    @(posedge pll_clock);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int n;
    bit en;

    // Reset held for two cycles.
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 0, 0);
    check("reset_code0", code_a[0 +: OUT_W], MID);
    check("reset_code1", code_a[OUT_W +: OUT_W], MID);
    check("reset_gain", gain_a, 0);

    // Full ramp up with a constant sample stream.
    n = 0;
    while (m_state != M_ACTIVE && n < 100) begin
      cycle(1'b0, 1'b1, 1'b1, 15, -16);
      n++;
    end
    check("ramp_up_full_gain", gain_a, FULL);
    repeat (4) cycle(1'b0, 1'b1, 1'b1, 15, -16);
    check("active_code0", code_a[0 +: OUT_W], 47);
    check("active_code1", code_a[OUT_W +: OUT_W], 16);
    check("msb_code0", code_b[0 +: OUT_W], 62);
    check("msb_code1", code_b[OUT_W +: OUT_W], 0);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 0, 0);
    check("msb_zero", code_b[0 +: OUT_W], 32);

    // Single strobe, then hold with sample_valid low.
    cycle(1'b0, 1'b1, 1'b1, 7, -3);
    repeat (6) cycle(1'b0, 1'b1, 1'b0, 0, 0);
    check("hold_code0", code_a[0 +: OUT_W], 39);
    check("hold_code1", code_a[OUT_W +: OUT_W], 29);

    // Mid-ramp: release enable at gain 8 and ramp back down to mute.
    cycle(1'b1, 1'b0, 1'b0, 0, 0);
    n = 0;
    while (m_gain < 8 && n < 100) begin
      cycle(1'b0, 1'b1, 1'b1, 15, -16);
      n++;
    end
    check("mid_gain_8", gain_a, 8);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 15, -16);
    check("mid_code0", code_a[0 +: OUT_W], 39);
    check("mid_code1", code_a[OUT_W +: OUT_W], 24);
    check("mid_msb_code0", code_b[0 +: OUT_W], 46);
    n = 0;
    while (!muted_a && n < 40) begin
      cycle(1'b0, 1'b0, 1'b1, 15, -16);
      n++;
    end
    check("ramp_down_muted", muted_a, 1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 15, -16);
    check("muted_code0", code_a[0 +: OUT_W], MID);
    check("muted_code1", code_a[OUT_W +: OUT_W], MID);

    // Reset in the middle of a ramp-up.
    n = 0;
    while (m_gain < 5 && n < 100) begin
      cycle(1'b0, 1'b1, 1'b1, -9, 11);
      n++;
    end
    check("pre_reset_gain", gain_a, 5);
    cycle(1'b1, 1'b1, 1'b1, -9, 11);
    check("mid_reset_gain", gain_a, 0);
    check("mid_reset_muted", muted_a, 1);
    check("mid_reset_code0", code_a[0 +: OUT_W], MID);
    check("mid_reset_valid", ov_a, 0);

    // Randomized traffic: enable toggles, sparse strobes, occasional reset.
    en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) en = !en;
      cycle($urandom_range(0, 499) == 0, en, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
